spram_fifo_arbiter: RTL and testbench

- FIFO controller and port arbiter for one single-ported SB_SPRAM256KA (16 bit x 16K words).
- The SPRAM allows only one read or write per cycle, so this block owns the write/read pointers and the occupancy count.
- Each cycle it grants the RAM to exactly one of the writer (e.g. UART RX hex encoder) or the reader (e.g. UART TX drain).
- A small write skid buffer ensures single-cycle write strobes are never lost while a read holds the RAM.

---
 rtl/spram_fifo_arbiter_pkg.sv | 14 +
 rtl/spram_fifo_arbiter_if.sv | 25 ++
 rtl/spram_fifo_arbiter_skid_fifo.sv | 50 +++++
 rtl/spram_fifo_arbiter.sv | 121 ++++++++++++
 tb/tb_spram_fifo_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spram_fifo_arbiter_pkg.sv
// Shared definitions for the SPRAM FIFO arbiter: grant encoding and default SPRAM geometry.
package spram_fifo_arbiter_pkg;

  localparam int unsigned DEF_ADDR_BITS  = 14;
  localparam int unsigned DEF_DATA_BITS  = 16;
  localparam int unsigned DEF_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_WRITE = 2'd1,
    GRANT_READ  = 2'd2
  } grant_e;

endpackage

// File: rtl/spram_fifo_arbiter_if.sv
// Client-side bus of the SPRAM FIFO arbiter: enqueue/dequeue strobes and status.
interface spram_fifo_arbiter_if #(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned DATA_BITS = 16
);
  logic [DATA_BITS-1:0] write_data;
  logic                 write_strobe;
  logic                 read_strobe;
  logic [DATA_BITS-1:0] read_data;
  logic                 read_valid;
  logic                 data_available;
  logic [ADDR_BITS:0]   count;
  logic                 full;
  logic                 overflow;

  modport master (
    output write_data, write_strobe, read_strobe,
    input  read_data, read_valid, data_available, count, full, overflow
  );

  modport slave (
    input  write_data, write_strobe, read_strobe,
    output read_data, read_valid, data_available, count, full, overflow
  );
endinterface

// File: rtl/spram_fifo_arbiter_skid_fifo.sv
// Small register FIFO absorbing write strobes while the SPRAM is busy with a read.
module skid_fifo #(
  parameter  int unsigned DATA_BITS  = 16,
  parameter  int unsigned SKID_DEPTH = 2,
  localparam int unsigned PTR_BITS   = $clog2(SKID_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_push_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_head,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [PTR_BITS:0]    o_level
);
  logic [DATA_BITS-1:0] r_mem [SKID_DEPTH];
  logic [PTR_BITS-1:0]  r_wr_idx;
  logic [PTR_BITS-1:0]  r_rd_idx;
  logic [PTR_BITS:0]    r_level;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_level == (PTR_BITS+1)'(SKID_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_idx];

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_idx] <= i_push_data;
  end

endmodule

// File: rtl/spram_fifo_arbiter.sv
// FIFO controller for a single-ported SPRAM: owns pointers and occupancy and
// grants the RAM each cycle to either the skid-buffered writer or the reader.
module spram_fifo_arbiter
  import spram_fifo_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  spram_fifo_arbiter_if.slave   bus,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_BITS-1:0]  ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_BITS-1:0]  ram_rdata
);
  localparam int unsigned       SKID_LVL_BITS = $clog2(SKID_DEPTH) + 1;
  localparam logic [ADDR_BITS:0] RAM_DEPTH    = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0]     r_wr_ptr;
  logic [ADDR_BITS-1:0]     r_rd_ptr;
  logic [ADDR_BITS:0]       r_count;
  logic                     r_read_pending;
  logic                     r_read_issued;
  logic                     r_read_valid;
  logic                     r_overflow;
  logic [ADDR_BITS-1:0]     r_ram_addr;
  logic [DATA_BITS-1:0]     r_ram_wdata;
  logic                     r_ram_wren;

  grant_e                   w_grant;
  logic                     w_full;
  logic                     w_write_urgent;
  logic                     w_data_available;
  logic                     w_read_accept;
  logic                     w_skid_full;
  logic                     w_skid_empty;
  logic [SKID_LVL_BITS-1:0] w_skid_level;
  logic [DATA_BITS-1:0]     w_skid_head;

  skid_fifo #(
    .DATA_BITS  (DATA_BITS),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_push      (bus.write_strobe),
    .i_push_data (bus.write_data),
    .i_pop       (w_grant == GRANT_WRITE),
    .o_head      (w_skid_head),
    .o_full      (w_skid_full),
    .o_empty     (w_skid_empty),
    .o_level     (w_skid_level)
  );

  assign w_full         = (r_count == RAM_DEPTH);
  assign w_write_urgent = (w_skid_level >= SKID_LVL_BITS'(SKID_DEPTH - 1)) && !w_full;

  always_comb begin
    w_grant = GRANT_IDLE;
    if (w_write_urgent)                 w_grant = GRANT_WRITE;
    else if (r_read_pending)            w_grant = GRANT_READ;
    else if (!w_skid_empty && !w_full)  w_grant = GRANT_WRITE;
  end

  // Only one read may be in flight, so a new request is refused until the current one is granted.
  assign w_data_available = (r_count != '0) && !r_read_pending && (w_grant != GRANT_READ);
  assign w_read_accept    = bus.read_strobe && w_data_available;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_read_pending <= 1'b0;
      r_read_issued  <= 1'b0;
      r_read_valid   <= 1'b0;
      r_overflow     <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_wdata    <= '0;
      r_ram_wren     <= 1'b0;
    end else begin
      r_ram_wren    <= 1'b0;
      r_read_issued <= 1'b0;
      // SPRAM registers the address one cycle after the grant, data follows one cycle later.
      r_read_valid  <= r_read_issued;
      if (w_read_accept) r_read_pending <= 1'b1;
      if (bus.write_strobe && w_skid_full) r_overflow <= 1'b1;
      case (w_grant)
        GRANT_WRITE: begin
          r_ram_addr  <= r_wr_ptr;
          r_ram_wdata <= w_skid_head;
          r_ram_wren  <= 1'b1;
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_count     <= r_count + 1'b1;
        end
        GRANT_READ: begin
          r_ram_addr     <= r_rd_ptr;
          r_rd_ptr       <= r_rd_ptr + 1'b1;
          r_count        <= r_count - 1'b1;
          r_read_pending <= 1'b0;
          r_read_issued  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wren  = r_ram_wren;

  assign bus.read_data      = ram_rdata;
  assign bus.read_valid     = r_read_valid;
  assign bus.data_available = w_data_available;
  assign bus.count          = r_count;
  assign bus.full           = w_full;
  assign bus.overflow       = r_overflow;

endmodule

// File: tb/tb_spram_fifo_arbiter.sv
// Directed bench for spram_fifo_arbiter: a 16K-word instance and a tiny 8-word instance, each with an SPRAM model.
module tb_spram_fifo_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spram_fifo_arbiter_if #(.ADDR_BITS(14), .DATA_BITS(16)) bus_a ();
  spram_fifo_arbiter_if #(.ADDR_BITS(3),  .DATA_BITS(16)) bus_b ();

  logic [13:0] ram_addr_a;
  logic [15:0] ram_wdata_a, ram_rdata_a;
  logic        ram_wren_a;
  logic [2:0]  ram_addr_b;
  logic [15:0] ram_wdata_b, ram_rdata_b;
  logic        ram_wren_b;

  spram_fifo_arbiter #(.ADDR_BITS(14), .DATA_BITS(16), .SKID_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_wren(ram_wren_a), .ram_rdata(ram_rdata_a)
  );

  spram_fifo_arbiter #(.ADDR_BITS(3), .DATA_BITS(16), .SKID_DEPTH(2)) u_dut_s (
    .clk(clk), .reset(reset), .bus(bus_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_wren(ram_wren_b), .ram_rdata(ram_rdata_b)
  );

  // SPRAM models: registered read, write on wren
  logic [15:0] mem_a [16384];
  logic [15:0] mem_b [8];
  always @(posedge clk) begin
    if (ram_wren_a) mem_a[ram_addr_a] <= ram_wdata_a;
    ram_rdata_a <= mem_a[ram_addr_a];
    if (ram_wren_b) mem_b[ram_addr_b] <= ram_wdata_b;
    ram_rdata_b <= mem_b[ram_addr_b];
  end

  logic [15:0] got_a [$];
  logic [15:0] exp_q [$];
  int unsigned max_lvl_a = 0;
  int unsigned vld_cnt_b = 0;
  always @(posedge clk) begin
    #1;
    if (bus_a.read_valid) got_a.push_back(bus_a.read_data);
    if (32'(u_dut.w_skid_level) > max_lvl_a) max_lvl_a = 32'(u_dut.w_skid_level);
    if (bus_b.read_valid) vld_cnt_b = vld_cnt_b + 1;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_a(input string tag, input logic [15:0] exp);
    int unsigned t;
    t = 0;
    while (!bus_a.data_available && t < 16) begin tick(); t++; end
    bus_a.read_strobe = 1'b1;
    tick();
    bus_a.read_strobe = 1'b0;
    t = 0;
    while (!bus_a.read_valid && t < 16) begin tick(); t++; end
    check({tag, "_vld"}, 32'(bus_a.read_valid), 32'd1);
    check(tag, 32'(bus_a.read_data), 32'(exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned vld_before;
    reset = 1'b1;
    bus_a.write_data = '0; bus_a.write_strobe = 1'b0; bus_a.read_strobe = 1'b0;
    bus_b.write_data = '0; bus_b.write_strobe = 1'b0; bus_b.read_strobe = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(bus_a.count), 32'd0);
    check("rst_valid", 32'(bus_a.read_valid), 32'd0);
    check("rst_avail", 32'(bus_a.data_available), 32'd0);
    check("rst_ovf",   32'(bus_a.overflow), 32'd0);
    check("rst_wren",  32'(ram_wren_a), 32'd0);
    check("rst_addr",  32'(ram_addr_a), 32'd0);
    check("rst_wdata", 32'(ram_wdata_a), 32'd0);
    check("rst_full",  32'(bus_a.full), 32'd0);

    // Single write, committed two edges after the strobe
    bus_a.write_data = 16'h4142; bus_a.write_strobe = 1'b1;
    tick();
    bus_a.write_strobe = 1'b0;
    check("w1_skid_only", 32'(bus_a.count), 32'd0);
    tick();
    check("w1_wren",  32'(ram_wren_a), 32'd1);
    check("w1_addr",  32'(ram_addr_a), 32'd0);
    check("w1_wdata", 32'(ram_wdata_a), 32'h4142);
    check("w1_count", 32'(bus_a.count), 32'd1);
    check("w1_avail", 32'(bus_a.data_available), 32'd1);

    // Single read: strobe at N, address at N+1, read_valid at N+2
    bus_a.read_strobe = 1'b1;
    tick();
    bus_a.read_strobe = 1'b0;
    check("r1_avail_pend", 32'(bus_a.data_available), 32'd0);
    check("r1_wren_clr",   32'(ram_wren_a), 32'd0);
    tick();
    check("r1_addr",  32'(ram_addr_a), 32'd0);
    check("r1_wren",  32'(ram_wren_a), 32'd0);
    check("r1_count", 32'(bus_a.count), 32'd0);
    check("r1_early", 32'(bus_a.read_valid), 32'd0);
    tick();
    check("r1_valid", 32'(bus_a.read_valid), 32'd1);
    check("r1_data",  32'(bus_a.read_data), 32'h4142);
    tick();
    check("r1_pulse", 32'(bus_a.read_valid), 32'd0);

    // Simultaneous read and write with three words stored
    for (int i = 0; i < 3; i++) begin
      bus_a.write_data = 16'h1111 * 16'(i + 1); bus_a.write_strobe = 1'b1;
      tick();
    end
    bus_a.write_strobe = 1'b0;
    tick(); tick();
    check("c3_count", 32'(bus_a.count), 32'd3);
    bus_a.write_data = 16'h4444; bus_a.write_strobe = 1'b1; bus_a.read_strobe = 1'b1;
    tick();
    bus_a.write_strobe = 1'b0; bus_a.read_strobe = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!bus_a.read_valid && lat < 8);
    check("c3_valid", 32'(bus_a.read_valid), 32'd1);
    check("c3_lat",   32'(lat <= 3), 32'd1);
    check("c3_data",  32'(bus_a.read_data), 32'h1111);
    tick();
    check("c3_count_back", 32'(bus_a.count), 32'd3);
    read_a("c3_d1", 16'h2222);
    read_a("c3_d2", 16'h3333);
    read_a("c3_d3", 16'h4444);
    check("c3_empty", 32'(bus_a.count), 32'd0);

    // Continuous writes with periodic read requests; order must be preserved
    got_a.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      bus_a.write_data = 16'h1000 + 16'(i);
      bus_a.write_strobe = 1'b1;
      exp_q.push_back(16'h1000 + 16'(i));
      bus_a.read_strobe = (i % 2 == 0);
      tick();
    end
    bus_a.write_strobe = 1'b0;
    bus_a.read_strobe = 1'b0;
    for (int i = 0; i < 400 && got_a.size() < 64; i++) begin
      bus_a.read_strobe = bus_a.data_available;
      tick();
    end
    bus_a.read_strobe = 1'b0;
    tick(); tick();
    check("s_nwords", got_a.size(), 32'd64);
    check("s_ovf",    32'(bus_a.overflow), 32'd0);
    check("s_count",  32'(bus_a.count), 32'd0);
    check("s_maxlvl", 32'(max_lvl_a <= 2), 32'd1);
    for (int i = 0; i < 64; i++)
      check("s_data", (i < got_a.size()) ? 32'(got_a[i]) : 32'hdead_beef, 32'(exp_q[i]));

    // Small RAM: fill, overflow the skid, then one read lets a word wrap to address 0
    for (int i = 0; i < 8; i++) begin
      bus_b.write_data = 16'h00B0 + 16'(i); bus_b.write_strobe = 1'b1;
      tick();
    end
    bus_b.write_strobe = 1'b0;
    tick(); tick();
    check("b_count8", 32'(bus_b.count), 32'd8);
    check("b_full",   32'(bus_b.full), 32'd1);
    check("b_ovf0",   32'(bus_b.overflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus_b.write_data = 16'h00C0 + 16'(i); bus_b.write_strobe = 1'b1;
      tick();
    end
    bus_b.write_strobe = 1'b0;
    check("b_ovf1",     32'(bus_b.overflow), 32'd1);
    check("b_skid2",    32'(u_dut_s.w_skid_level), 32'd2);
    check("b_count_st", 32'(bus_b.count), 32'd8);
    check("b_avail",    32'(bus_b.data_available), 32'd1);
    bus_b.read_strobe = 1'b1;
    tick();
    bus_b.read_strobe = 1'b0;
    tick();
    check("b_raddr",  32'(ram_addr_b), 32'd0);
    check("b_rwren",  32'(ram_wren_b), 32'd0);
    check("b_count7", 32'(bus_b.count), 32'd7);
    tick();
    check("b_valid",  32'(bus_b.read_valid), 32'd1);
    check("b_rdata",  32'(bus_b.read_data), 32'h00B0);
    check("b_waddr",  32'(ram_addr_b), 32'd0);
    check("b_wwren",  32'(ram_wren_b), 32'd1);
    check("b_wdata",  32'(ram_wdata_b), 32'h00C0);
    check("b_count8b", 32'(bus_b.count), 32'd8);
    check("b_full2",  32'(bus_b.full), 32'd1);
    tick();

    // Reset one cycle after a read grant suppresses the pending read_valid
    bus_b.read_strobe = 1'b1;
    tick();
    bus_b.read_strobe = 1'b0;
    tick();
    vld_before = vld_cnt_b;
    reset = 1'b1;
    tick();
    check("x_valid", 32'(bus_b.read_valid), 32'd0);
    check("x_count", 32'(bus_b.count), 32'd0);
    check("x_ovf",   32'(bus_b.overflow), 32'd0);
    check("x_avail", 32'(bus_b.data_available), 32'd0);
    check("x_wren",  32'(ram_wren_b), 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    check("x_nopulse", vld_cnt_b, vld_before);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
